// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbiter for the single register-file write port.
// Grants one of N_REQ requesters, drives a one-cycle rf_we, then a one-cycle ack.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous, active-high reset
//   req       - per-requester write request (level, held until ack)
//   req_addr  - packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  - packed data, requester i at [i*DATA_W +: DATA_W]
//   lock      - per-requester burst lock (only with RF_ARB_LOCK_EN)
//   grant     - one-hot current owner, zero when idle
//   ack       - one-cycle completion pulse to the owner
//   rf_we     - register-file write enable
//   rf_addr   - register-file write address
//   rf_data   - register-file write data
//   busy      - high whenever the arbiter is not idle
//
// Optional feature macro: RF_ARB_LOCK_EN (adds lock input and burst re-grant).
module rf_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
`ifdef RF_ARB_LOCK_EN
    input  logic [N_REQ-1:0]         lock,
`endif
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         ack,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_addr,
    output logic [DATA_W-1:0]        rf_data,
    output logic                     busy
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        ACK
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] win;

    // Arbitration result for the current cycle
    logic [IDX_W-1:0]  pick;
    logic [IDX_W:0]    cand;
    logic              found;
    logic [N_REQ-1:0]  pick_oh;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_data;

    // Scan last+1, last+2, ... wrapping at N_REQ; first set bit wins.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = {1'b0, last} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        pick_oh       = '0;
        pick_oh[pick] = 1'b1;
        pick_addr     = req_addr[pick*ADDR_W +: ADDR_W];
        pick_data     = req_data[pick*DATA_W +: DATA_W];
    end

`ifdef RF_ARB_LOCK_EN
    localparam logic [2:0] LOCK_MAX = 3'd4;

    // Consecutive grants to the current owner, including the first one
    logic [2:0]        lock_cnt;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic              relock;

    always_comb begin
        hold_addr = req_addr[win*ADDR_W +: ADDR_W];
        hold_data = req_data[win*DATA_W +: DATA_W];
        relock    = lock[win] && req[win] && (lock_cnt != LOCK_MAX);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            ack     <= '0;
            rf_we   <= 1'b0;
            rf_addr <= '0;
            rf_data <= '0;
            busy    <= 1'b0;
            last    <= IDX_W'(N_REQ-1);
            win     <= '0;
`ifdef RF_ARB_LOCK_EN
            lock_cnt <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        grant   <= pick_oh;
                        win     <= pick;
                        rf_addr <= pick_addr;
                        rf_data <= pick_data;
                        rf_we   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= WRITE;
`ifdef RF_ARB_LOCK_EN
                        lock_cnt <= 3'd1;
`endif
                    end
                end
                WRITE: begin
                    rf_we <= 1'b0;
                    ack   <= grant;
                    last  <= win;
                    state <= ACK;
                end
                ACK: begin
                    ack <= '0;
`ifdef RF_ARB_LOCK_EN
                    // Locked owner keeps the port; grant and busy stay high
                    if (relock) begin
                        rf_addr  <= hold_addr;
                        rf_data  <= hold_data;
                        rf_we    <= 1'b1;
                        lock_cnt <= lock_cnt + 3'd1;
                        state    <= WRITE;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`else
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of the CPU register file (an array of d_flip_flop words) between N_REQ requesters, e.g. ALU writeback, load unit and debug port.
- Grants requests round-robin and captures the winner's address and data.
- Drives one clean write-enable cycle into the register file, then returns a one-cycle ack to the winner.
- Sits between the execute/writeback stages and the register file.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 3, register address width
- DATA_W, 8, register data width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-requester write request, level; held until ack
- req_addr  input  N_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  input  N_REQ*DATA_W  packed data; requester i at bits [i*DATA_W +: DATA_W]
- grant  output  N_REQ  one-hot current owner; zero when idle
- ack  output  N_REQ  one-cycle completion pulse to the owner
- rf_we  output  1  register-file write enable
- rf_addr  output  ADDR_W  register-file write address
- rf_data  output  DATA_W  register-file write data
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-high:
  - state=IDLE.
  - grant, ack, rf_we, rf_addr, rf_data and busy all 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 has top priority first.
- States are IDLE, WRITE and ACK. All outputs are registered.
- IDLE:
  - If req != 0, select winner w = first set bit searching last+1, last+2, ... modulo N_REQ.
  - At the edge: register grant=onehot(w), rf_addr=req_addr[w], rf_data=req_data[w], rf_we=1, busy=1, and go to WRITE.
  - If req == 0, stay in IDLE.
- WRITE (exactly 1 cycle):
  - rf_we=1; the register file captures on the edge ending this cycle.
  - At the edge: rf_we=0, ack=onehot(w), last=w, go to ACK.
- ACK (exactly 1 cycle):
  - ack and grant are high for this cycle.
  - At the edge: ack=0, grant=0, busy=0, go to IDLE.
- Latency: req sampled at edge k gives rf_we high in cycle k+1 and ack high in cycle k+2. Back-to-back writes from different requesters occur every 3 cycles.
- Requester contract:
  - Addr/data must be stable only at the sampling edge; they are captured then.
  - Requester must deassert req at the edge where it observes ack=1. A req still high in IDLE is a new request.
- Mid-operation rules:
  - A req dropped during WRITE/ACK is ignored; the captured write completes and ack is still issued.
  - New reqs arriving during WRITE/ACK wait for IDLE. There is no lost-request or queue state.
- Fairness: a requester that keeps requesting waits at most N_REQ-1 grants.
- rf_addr/rf_data hold their last values in IDLE; only rf_we qualifies them.
- Reset asserted in WRITE aborts the write: rf_we drops immediately and no ack is issued.

Optional Feature:
- Macro: RF_ARB_LOCK_EN.
- Defined:
  - Adds input lock (N_REQ bits).
  - If lock[w] is high at the edge ending ACK and req[w] is high, skip IDLE and go directly to WRITE with w re-granted. The new req_addr[w]/req_data[w] are captured at that edge, giving burst writes every 2 cycles.
  - The pointer is not advanced past w while locked.
  - Lock is honoured for at most 4 consecutive grants; the 5th request arbitrates normally.
- Not defined: no lock port; behaviour exactly as above.

Test Plan:
- Reset, then idle 5 cycles -> grant=0, ack=0, rf_we=0, busy=0 throughout.
- req=0001, addr0=3, data0=8'hA5 at edge k -> rf_we=1, rf_addr=3, rf_data=A5 in cycle k+1; ack=0001 in cycle k+2 only; then IDLE.
- req=1111 held, each requester dropping req on its ack -> grant order 0,1,2,3. Then requester 0 alone raises req -> it is granted at next IDLE.
- req=0011 continuously, each re-raising req the cycle after ack -> grants alternate 0,1,0,1. No requester is granted twice in a row.
- Assert reset during WRITE -> rf_we, grant and busy are 0 immediately, no ack pulse, pointer returns to N_REQ-1.
- RF_ARB_LOCK_EN defined: lock=0100, req=0100 held for 6 writes, req[0] also high -> requester 2 gets 4 writes spaced 2 cycles apart, then requester 0 is granted.
